// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter that lets S_COUNT AXI-lite read masters share one AXI-lite read slave.
// One read is in flight at a time. The AR payload is registered, and R is routed back combinationally.
module axil_rd_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LSB_HIGH   = 1,
    localparam int CL_S      = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [S_COUNT*3-1:0]          s_axil_arprot,
    input  logic [S_COUNT-1:0]            s_axil_arvalid,
    output logic [S_COUNT-1:0]            s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
    output logic [S_COUNT*2-1:0]          s_axil_rresp,
    output logic [S_COUNT-1:0]            s_axil_rvalid,
    input  logic [S_COUNT-1:0]            s_axil_rready,
    output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
    output logic [2:0]                    m_axil_arprot,
    output logic                          m_axil_arvalid,
    input  logic                          m_axil_arready,
    input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
    input  logic [1:0]                    m_axil_rresp,
    input  logic                          m_axil_rvalid,
    output logic                          m_axil_rready,
    output logic                          grant_valid,
    output logic [CL_S-1:0]               grant_index
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } state_t;

    state_t                 state;
    logic [CL_S-1:0]        rr_ptr;
    logic [ADDR_WIDTH-1:0]  araddr_reg;
    logic [2:0]             arprot_reg;

    logic                   found;
    logic [CL_S-1:0]        sel;
    logic [S_COUNT-1:0]     sel_onehot;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [2:0]             sel_prot;
    int                     idx;

    // Search starts at rr_ptr and wraps. With LSB_HIGH=0 and ptr at 0, the highest index wins instead.
    always_comb begin
        found      = 1'b0;
        sel        = '0;
        sel_onehot = '0;
        sel_addr   = '0;
        sel_prot   = '0;
        idx        = 0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (LSB_HIGH == 0 && rr_ptr == '0) begin
                idx = S_COUNT - 1 - k;
            end else begin
                idx = int'(rr_ptr) + k;
                if (idx >= S_COUNT) begin
                    idx = idx - S_COUNT;
                end
            end
            if (!found && s_axil_arvalid[idx]) begin
                found           = 1'b1;
                sel             = CL_S'(idx);
                sel_onehot[idx] = 1'b1;
                sel_addr        = s_axil_araddr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                sel_prot        = s_axil_arprot[idx*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_index <= '0;
            rr_ptr      <= '0;
            araddr_reg  <= '0;
            arprot_reg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_index <= sel;
                        araddr_reg  <= sel_addr;
                        arprot_reg  <= sel_prot;
                        state       <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axil_arready) begin
                        state <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axil_rvalid && s_axil_rready[grant_index]) begin
                        rr_ptr <= (grant_index == CL_S'(S_COUNT - 1)) ? '0 : grant_index + 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake-facing outputs are gated by rst so nothing leaks out while reset is held.
    always_comb begin
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        if (!rst && state == ST_IDLE && found) begin
            s_axil_arready = sel_onehot;
        end
        for (int i = 0; i < S_COUNT; i++) begin
            if (!rst && state == ST_R && grant_index == CL_S'(i)) begin
                s_axil_rvalid[i] = m_axil_rvalid;
            end
        end
    end

    assign m_axil_rready  = !rst && (state == ST_R) && s_axil_rready[grant_index];
    assign m_axil_arvalid = (state == ST_AR);
    assign grant_valid    = (state != ST_IDLE);
    assign m_axil_araddr  = araddr_reg;
    assign m_axil_arprot  = arprot_reg;
    assign s_axil_rdata   = {S_COUNT{m_axil_rdata}};
    assign s_axil_rresp   = {S_COUNT{m_axil_rresp}};

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter: vector table, reset and continuous-request sequences,
// then randomized transactions checked against a round-robin reference model.
module tb_axil_rd_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] s_araddr;
    logic [N*3-1:0]  s_arprot;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [N*DW-1:0] s_rdata;
    logic [N*2-1:0]  s_rresp;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [AW-1:0]   m_araddr;
    logic [2:0]      m_arprot;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rvalid;
    logic            m_rready;
    logic            grant_valid;
    logic [1:0]      grant_index;

    int compared   = 0;
    int mismatched = 0;
    int model_ptr  = 0;

    always #5 clk = ~clk;

    axil_rd_arbiter #(
        .S_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LSB_HIGH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot),
        .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
        .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
        .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot),
        .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
        .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    typedef struct {
        logic [3:0]  req;
        int          exp_grant;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_wait;
        int          r_hold;
    } vec_t;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the first requester found when scanning upward from the pointer, wrapping around.
    function automatic int modelGrant(input logic [3:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return 0;
    endfunction

    // Runs one full transaction starting just after a negedge with the DUT in IDLE.
    task automatic applyStimulus(input logic [3:0] req, input int exp_g, input logic [31:0] addr,
                                 input logic [2:0] prot, input logic [31:0] rdata,
                                 input logic [1:0] rresp, input int ar_wait, input int r_hold);
        logic [3:0] onehot;
        onehot = 4'b0001 << exp_g;
        for (int i = 0; i < N; i++) begin
            s_araddr[i*AW +: AW] = (i == exp_g) ? addr : $urandom;
            s_arprot[i*3 +: 3]   = (i == exp_g) ? prot : 3'($urandom);
        end
        s_arvalid = req;
        #1;
        checkOutput("idle_grant_valid", grant_valid, 0);
        checkOutput("idle_arready", s_arready, onehot);
        checkOutput("idle_m_arvalid", m_arvalid, 0);
        @(negedge clk);
        s_arvalid = req & ~onehot;
        for (int c = 0; c <= ar_wait; c++) begin
            m_arready = (c == ar_wait);
            m_rvalid  = 1'($urandom);
            s_rready  = 4'($urandom);
            #1;
            checkOutput("ar_m_arvalid", m_arvalid, 1);
            checkOutput("ar_m_araddr", m_araddr, addr);
            checkOutput("ar_m_arprot", m_arprot, prot);
            checkOutput("ar_s_arready", s_arready, 0);
            checkOutput("ar_grant_index", grant_index, exp_g);
            checkOutput("ar_grant_valid", grant_valid, 1);
            checkOutput("ar_s_rvalid", s_rvalid, 0);
            checkOutput("ar_m_rready", m_rready, 0);
            @(negedge clk);
        end
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = rdata;
        m_rresp   = rresp;
        for (int c = 0; c <= r_hold; c++) begin
            s_rready = (c == r_hold) ? (4'($urandom) | onehot) : (4'($urandom) & ~onehot);
            #1;
            checkOutput("r_s_rvalid", s_rvalid, onehot);
            checkOutput("r_m_rready", m_rready, (c == r_hold) ? 1 : 0);
            checkOutput("r_s_rdata", s_rdata, {N{rdata}});
            checkOutput("r_s_rresp", s_rresp, {N{rresp}});
            checkOutput("r_m_arvalid", m_arvalid, 0);
            checkOutput("r_s_arready", s_arready, 0);
            checkOutput("r_grant_index", grant_index, exp_g);
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        s_rready = '0;
        #1;
        checkOutput("done_grant_valid", grant_valid, 0);
        model_ptr = (exp_g + 1) % N;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b0100, 2, 32'h0000_1000, 3'd0, 32'hDEAD_BEEF, 2'd0, 0, 0};
        vecs[1] = '{4'b1111, 3, 32'h1234_5678, 3'd5, 32'h0BAD_F00D, 2'd2, 5, 0};
        vecs[2] = '{4'b1111, 0, 32'hA5A5_0000, 3'd1, 32'h1111_2222, 2'd1, 0, 3};
        vecs[3] = '{4'b1111, 1, 32'h0000_0004, 3'd7, 32'h3333_4444, 2'd3, 1, 1};
        vecs[4] = '{4'b1111, 2, 32'hFFFF_FFFC, 3'd2, 32'h5555_6666, 2'd0, 0, 0};
        vecs[5] = '{4'b1010, 3, 32'h0300_0030, 3'd3, 32'h7777_8888, 2'd0, 2, 0};
        vecs[6] = '{4'b1010, 1, 32'h0100_0010, 3'd4, 32'h9999_AAAA, 2'd2, 0, 2};
        vecs[7] = '{4'b0001, 0, 32'h0000_0000, 3'd6, 32'hBBBB_CCCC, 2'd1, 0, 0};
        vecs[8] = '{4'b1000, 3, 32'hCAFE_0000, 3'd1, 32'hDDDD_EEEE, 2'd0, 1, 1};
        vecs[9] = '{4'b0110, 1, 32'h8000_0000, 3'd0, 32'hFFFF_0000, 2'd3, 0, 0};

        rst       = 1'b1;
        s_araddr  = '0;
        s_arprot  = '0;
        s_arvalid = 4'b1111;
        s_rready  = 4'b1111;
        m_arready = 1'b1;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_grant_valid", grant_valid, 0);
        checkOutput("rst_s_arready", s_arready, 0);
        checkOutput("rst_s_rvalid", s_rvalid, 0);
        checkOutput("rst_m_arvalid", m_arvalid, 0);
        checkOutput("rst_m_rready", m_rready, 0);
        checkOutput("rst_m_araddr", m_araddr, 0);
        checkOutput("rst_grant_index", grant_index, 0);
        rst       = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].req, vecs[v].exp_grant, vecs[v].addr, vecs[v].prot,
                          vecs[v].rdata, vecs[v].rresp, vecs[v].ar_wait, vecs[v].r_hold);
        end

        // Reset taken in the R state must abandon the read and clear the pointer.
        s_arvalid = 4'b0100;
        @(negedge clk);
        s_arvalid = '0;
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        s_rready  = '0;
        #1;
        checkOutput("mid_r_s_rvalid", s_rvalid, 4'b0100);
        rst       = 1'b1;
        s_arvalid = 4'b0100;
        @(negedge clk);
        #1;
        checkOutput("midrst_grant_valid", grant_valid, 0);
        checkOutput("midrst_s_rvalid", s_rvalid, 0);
        checkOutput("midrst_m_rready", m_rready, 0);
        checkOutput("midrst_m_arvalid", m_arvalid, 0);
        checkOutput("midrst_s_arready", s_arready, 0);
        checkOutput("midrst_m_araddr", m_araddr, 0);
        rst       = 1'b0;
        m_rvalid  = 1'b0;
        s_arvalid = '0;
        @(negedge clk);
        model_ptr = 0;

        // All four requesting continuously after reset: grants rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, k % N, $urandom, 3'($urandom), $urandom, 2'($urandom), 0, 0);
        end

        for (int t = 0; t < 40; t++) begin
            logic [3:0] req;
            req = 4'($urandom_range(1, 15));
            applyStimulus(req, modelGrant(req), $urandom, 3'($urandom), $urandom, 2'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
